// File: rtl/addr_decode_ws_pkg.sv
// Shared constants for the data-bus address decoder: system region map, FSM
// state encoding and field widths.
package addr_decode_ws_pkg;

    localparam int unsigned IdxW = 3;
    localparam int unsigned WsW  = 4;

    localparam logic [31:0] RamBase   = 32'h0000_0500;
    localparam logic [31:0] RamLimit  = 32'h0000_08FF;
    localparam logic [31:0] MmioBase  = 32'h0000_1000;
    localparam logic [31:0] MmioLimit = 32'h0000_10FF;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StErr    = 2'd2
    } state_e;

endpackage

// File: rtl/addr_region_match.sv
// Single inclusive [BASE, LIMIT] window compare; a window with LIMIT < BASE
// can never hit.
module addr_region_match #(
    parameter int unsigned        ADDR_W = 32,
    parameter logic [ADDR_W-1:0]  BASE   = '0,
    parameter logic [ADDR_W-1:0]  LIMIT  = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit
);

    assign hit = (addr >= BASE) && (addr <= LIMIT);

endmodule

// File: rtl/addr_decode_ws.sv
// Multi-region address decoder: priority-selects the lowest-index hit region,
// holds its active-low chip select for the region's wait states, then acks.
module addr_decode_ws
    import addr_decode_ws_pkg::*;
#(
    parameter int unsigned              ADDR_W    = 32,
    parameter int unsigned              N_REG     = 4,
    parameter logic [N_REG*ADDR_W-1:0]  REG_BASE  = (N_REG*ADDR_W)'(RamBase),
    parameter logic [N_REG*ADDR_W-1:0]  REG_LIMIT = (N_REG*ADDR_W)'(RamLimit),
    parameter logic [N_REG*WsW-1:0]     REG_WS    = '0,
    parameter bit                       ALIGN_CHK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic [N_REG-1:0]  cs_n,
    output logic              ready,
    output logic              bus_err,
    output logic [IdxW-1:0]   sel_idx
);

    logic [N_REG-1:0] hit;
    logic             hit_any;
    logic [IdxW-1:0]  hit_idx;
    logic [WsW-1:0]   hit_ws;
    logic             aligned;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [WsW-1:0]  cnt_q, cnt_d;
    logic            active;

    for (genvar i = 0; i < N_REG; i++) begin : g_region
        addr_region_match #(
            .ADDR_W (ADDR_W),
            .BASE   (REG_BASE[i*ADDR_W +: ADDR_W]),
            .LIMIT  (REG_LIMIT[i*ADDR_W +: ADDR_W])
        ) u_match (
            .addr (addr),
            .hit  (hit[i])
        );
    end

    // Scan from the top so the lowest hitting index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        hit_ws  = '0;
        for (int i = N_REG - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IdxW'(i);
                hit_ws  = REG_WS[i*WsW +: WsW];
            end
        end
    end

    assign aligned = !ALIGN_CHK || (addr[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (hit_any && aligned) begin
                        idx_d   = hit_idx;
                        cnt_d   = hit_ws;
                        state_d = StActive;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StActive: begin
                // Dropping req aborts the access without an acknowledge.
                if (!req || (cnt_q == '0)) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs come straight from registered state so they cannot glitch.
    assign active = (state_q == StActive);

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < N_REG; i++) begin
            cs_n[i] = !(active && (idx_q == IdxW'(i)));
        end
    end

    assign ready   = active && (cnt_q == '0);
    assign bus_err = (state_q == StErr);
    assign sel_idx = active ? idx_q : '0;

endmodule

// File: tb/tb_addr_decode_ws.sv
// Self-checking bench for addr_decode_ws: directed vector table, multi-cycle
// corner sequences and random accesses against a transaction-level model.
module tb_addr_decode_ws;

    localparam int N = 4;

    // Region 2 overlaps region 0 at 0x600; region 3 has LIMIT < BASE.
    localparam logic [31:0] M_BASE  [N] = '{32'h0000_0500, 32'h0000_1000,
                                            32'h0000_0600, 32'h0000_3000};
    localparam logic [31:0] M_LIMIT [N] = '{32'h0000_08FF, 32'h0000_10FF,
                                            32'h0000_06FF, 32'h0000_2FFF};
    localparam int          M_WS    [N] = '{0, 3, 1, 2};

    localparam logic [N*32-1:0] P_BASE  = {32'h0000_3000, 32'h0000_0600,
                                           32'h0000_1000, 32'h0000_0500};
    localparam logic [N*32-1:0] P_LIMIT = {32'h0000_2FFF, 32'h0000_06FF,
                                           32'h0000_10FF, 32'h0000_08FF};
    localparam logic [N*4-1:0]  P_WS    = {4'd2, 4'd1, 4'd3, 4'd0};

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [31:0]   addr;
    logic [N-1:0]  cs_n;
    logic          ready;
    logic          bus_err;
    logic [2:0]    sel_idx;

    int tests = 0;
    int fails = 0;

    addr_decode_ws #(
        .ADDR_W    (32),
        .N_REG     (N),
        .REG_BASE  (P_BASE),
        .REG_LIMIT (P_LIMIT),
        .REG_WS    (P_WS),
        .ALIGN_CHK (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .addr    (addr),
        .cs_n    (cs_n),
        .ready   (ready),
        .bus_err (bus_err),
        .sel_idx (sel_idx)
    );

    always #5 clk = ~clk;

    // At most one chip select may ever be low.
    always @(negedge clk) begin
        tests++;
        if ($countones(~cs_n) > 1) begin
            fails++;
            $display("FAIL onehot_cs: cs_n=%b, required at most one bit low", cs_n);
        end
    end

    // Reference: lowest-index inclusive window, aligned only; -1 means bus error.
    function automatic int model_region(input logic [31:0] a);
        if (a[1:0] != 2'b00) return -1;
        for (int i = 0; i < N; i++) begin
            if (M_BASE[i] <= a && a <= M_LIMIT[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [N-1:0] e_cs, input logic e_rdy,
                         input logic e_err, input int e_sel);
        tests++;
        if (cs_n !== e_cs || ready !== e_rdy || bus_err !== e_err ||
            (e_sel >= 0 && sel_idx !== 3'(e_sel))) begin
            fails++;
            $display("FAIL %s: got cs_n=%b ready=%b bus_err=%b sel_idx=%0d, required cs_n=%b ready=%b bus_err=%b sel_idx=%0d",
                     name, cs_n, ready, bus_err, sel_idx, e_cs, e_rdy, e_err, e_sel);
        end
    endtask

    // Full access with req held to completion, then one idle check after.
    task automatic do_access(input string name, input logic [31:0] a, input int r, input int ws);
        logic [N-1:0] one;
        req  = 1'b1;
        addr = a;
        step();
        if (r < 0) begin
            check({name, "_err"}, '1, 1'b0, 1'b1, -1);
        end else begin
            one = N'(1) << r;
            for (int k = 0; k <= ws; k++) begin
                check({name, "_cs"}, ~one, (k == ws), 1'b0, r);
                if (k < ws) step();
            end
        end
        req = 1'b0;
        step();
        check({name, "_idle"}, '1, 1'b0, 1'b0, -1);
    endtask

    typedef struct {
        logic [31:0] a;
        int          r;
        int          ws;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] ra;
        int          rr;

        rst  = 1'b1;
        req  = 1'b0;
        addr = '0;
        step();
        step();
        check("reset", '1, 1'b0, 1'b0, 0);
        rst = 1'b0;
        step();

        vecs.push_back('{32'h0000_04FC, -1, 0, "below_ram"});
        vecs.push_back('{32'h0000_0500,  0, 0, "ram_base"});
        vecs.push_back('{32'h0000_08FC,  0, 0, "ram_top"});
        vecs.push_back('{32'h0000_0900, -1, 0, "above_ram"});
        vecs.push_back('{32'h0000_1004,  1, 3, "mmio_ws3"});
        vecs.push_back('{32'h0000_10FC,  1, 3, "mmio_top"});
        vecs.push_back('{32'h0000_0600,  0, 0, "overlap"});
        vecs.push_back('{32'h0000_0602, -1, 0, "misaligned"});
        vecs.push_back('{32'h0000_2800, -1, 0, "inverted_win"});
        vecs.push_back('{32'hFFFF_FFFC, -1, 0, "top_of_space"});
        foreach (vecs[i]) do_access(vecs[i].name, vecs[i].a, vecs[i].r, vecs[i].ws);

        // Abort: req dropped after the first active cycle.
        req  = 1'b1;
        addr = 32'h0000_1004;
        step();
        check("abort_cs", 4'hD, 1'b0, 1'b0, 1);
        req = 1'b0;
        step();
        check("abort_release", 4'hF, 1'b0, 1'b0, -1);
        step();
        check("abort_idle", 4'hF, 1'b0, 1'b0, -1);

        // Reset in the middle of the wait.
        req = 1'b1;
        step();
        step();
        check("midrst_wait", 4'hD, 1'b0, 1'b0, 1);
        rst = 1'b1;
        step();
        check("midrst_reset", 4'hF, 1'b0, 1'b0, 0);
        rst = 1'b0;
        req = 1'b0;
        step();
        check("midrst_idle", 4'hF, 1'b0, 1'b0, -1);

        // Back-to-back with req held: one idle gap between ready pulses.
        req  = 1'b1;
        addr = 32'h0000_1004;
        for (int k = 0; k <= 3; k++) begin
            step();
            check("b2b_first", 4'hD, (k == 3), 1'b0, 1);
        end
        addr = 32'h0000_0500;
        step();
        check("b2b_gap", 4'hF, 1'b0, 1'b0, -1);
        step();
        check("b2b_second", 4'hE, 1'b1, 1'b0, 0);
        req = 1'b0;
        step();
        check("b2b_idle", 4'hF, 1'b0, 1'b0, -1);

        // Random accesses around the mapped windows.
        for (int n = 0; n < 60; n++) begin
            ra = 32'($urandom_range(32'h0000_0480, 32'h0000_1140));
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            rr = model_region(ra);
            do_access("rand", ra, rr, (rr < 0) ? 0 : M_WS[rr]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
